fadd_sched: RTL and testbench

Round-robin scheduler that shares one combinational single-precision adder (fadd: x1, x2 -> y, ovf) among NREQ requesters.
- Arbitrates requests and registers the winning operands onto the adder inputs.
- Holds them for LAT cycles so the adder path can be constrained as a multicycle path.
- Captures the sum and returns it with the requester id over a valid/ready response channel.
- Keeps a saturating count of overflow results.

---
 rtl/fadd_sched_if.sv | 30 +++
 rtl/fadd_sched.sv | 148 ++++++++++++++
 tb/tb_fadd_sched.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fadd_sched_if.sv
`default_nettype none
// ============================================================================
// fadd_sched_if : request / response channels of the shared-adder scheduler
// Rev 1.0
// ============================================================================
interface fadd_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [32*NREQ-1:0] req_x1;
    logic [32*NREQ-1:0] req_x2;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_y;
    logic               rsp_ovf;

    modport master (
        output req_valid, req_x1, req_x2, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_ovf
    );

    modport slave (
        input  req_valid, req_x1, req_x2, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y, rsp_ovf
    );
endinterface
`default_nettype wire

// File: rtl/fadd_sched.sv
`default_nettype none
// ============================================================================
// fadd_sched : round-robin scheduler sharing one combinational fp adder
// Rev 1.0
// ============================================================================
module fadd_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 1
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    fadd_sched_if.slave      bus,
    output logic [31:0]      fa_x1,
    output logic [31:0]      fa_x2,
    input  wire logic [31:0] fa_y,
    input  wire logic        fa_ovf,
    output logic             busy,
    output logic [15:0]      ovf_cnt
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] c_CNT_INIT = 4'(LAT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_id;
    logic [3:0]         r_cnt;
    logic [31:0]        r_fa_x1;
    logic [31:0]        r_fa_x2;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [31:0]        r_rsp_y;
    logic               r_rsp_ovf;
    logic [15:0]        r_ovf_cnt;

    logic [2*NREQ-1:0]  w_dbl;
    logic [NREQ-1:0]    w_rot;
    logic               w_found;
    logic [IDW-1:0]     w_off;
    logic [IDW:0]       w_sum;
    logic [IDW-1:0]     w_gnt;
    logic [31:0]        w_x1;
    logic [31:0]        w_x2;
    logic [NREQ-1:0]    w_req_ready;

    // Rotate the request vector so bit 0 is rr_ptr; the lowest set bit wins.
    always_comb begin
        w_dbl   = {bus.req_valid, bus.req_valid} >> r_rr_ptr;
        w_rot   = w_dbl[NREQ-1:0];
        w_found = |w_rot;
        w_off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = IDW'(k);
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_sum >= (IDW+1)'(NREQ)) w_sum = w_sum - (IDW+1)'(NREQ);
        w_gnt = w_sum[IDW-1:0];
    end

    always_comb begin
        w_req_ready = '0;
        w_x1        = '0;
        w_x2        = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt == IDW'(i)) begin
                w_x1           = bus.req_x1[32*i +: 32];
                w_x2           = bus.req_x2[32*i +: 32];
                w_req_ready[i] = (r_state == S_IDLE) && w_found && rstn;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found)        w_state_nxt = S_EXEC;
            S_EXEC:  if (r_cnt == 4'd0)  w_state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready)  w_state_nxt = S_IDLE;
            default:                     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_cnt       <= 4'd0;
            r_fa_x1     <= 32'd0;
            r_fa_x2     <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_y     <= 32'd0;
            r_rsp_ovf   <= 1'b0;
            r_ovf_cnt   <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_fa_x1 <= w_x1;
                        r_fa_x2 <= w_x2;
                        r_id    <= w_gnt;
                        r_cnt   <= c_CNT_INIT;
                    end
                end
                S_EXEC: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rsp_y     <= fa_y;
                        r_rsp_ovf   <= fa_ovf;
                        r_rsp_id    <= r_id;
                        r_rsp_valid <= 1'b1;
                        if (fa_ovf && (r_ovf_cnt != 16'hFFFF)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rr_ptr    <= (r_rsp_id == IDW'(NREQ - 1)) ? '0 : r_rsp_id + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_y     = r_rsp_y;
    assign bus.rsp_ovf   = r_rsp_ovf;
    assign fa_x1         = r_fa_x1;
    assign fa_x2         = r_fa_x2;
    assign busy          = (r_state != S_IDLE);
    assign ovf_cnt       = r_ovf_cnt;
endmodule
`default_nettype wire

// File: tb/tb_fadd_sched.sv
`default_nettype none
// ============================================================================
// tb_fadd_sched : randomized self-checking bench against a transaction model
// Rev 1.0
// ============================================================================
module tb_fadd_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 1;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int     n_chk  = 0;
    int     n_fail = 0;
    int     m_ptr  = 0;
    int     m_ovf  = 0;
    longint last_t = -1;
    logic [31:0] x1s [NREQ];
    logic [31:0] x2s [NREQ];

    // Reference single-precision adder (normal operands, round to nearest even)
    function automatic real s2r(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) return 0.0;
        d = {b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [32:0] fadd_ref(input logic [31:0] a, input logic [31:0] b);
        real         s;
        logic [63:0] d;
        int          e;
        logic [24:0] m;
        s = s2r(a) + s2r(b);
        d = $realtobits(s);
        e = int'(d[62:52]) - 1023 + 127;
        if (d[62:52] == 11'd0 || e < 1) return {1'b0, d[63], 31'd0};
        m = {1'b0, 1'b1, d[51:29]};
        if (d[28] && ((|d[27:0]) || m[0])) m = m + 25'd1;
        if (m[24]) begin
            e = e + 1;
            m = m >> 1;
        end
        if (e >= 255) return {1'b1, d[63], 8'hFF, 23'd0};
        return {1'b0, d[63], 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_f();
        logic [7:0] e;
        e = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(250, 254)) : 8'($urandom_range(100, 154));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // ---------------- DUT with LAT=1 ----------------
    fadd_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
    logic [31:0] fa_x1, fa_x2, fa_y;
    logic        fa_ovf, busy;
    logic [15:0] ovf_cnt;
    assign {fa_ovf, fa_y} = fadd_ref(fa_x1, fa_x2);

    fadd_sched #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) u_dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .fa_x1(fa_x1), .fa_x2(fa_x2), .fa_y(fa_y), .fa_ovf(fa_ovf),
        .busy(busy), .ovf_cnt(ovf_cnt)
    );

    // ---------------- DUT with LAT=3, adder output can be overridden ----------------
    fadd_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus3 ();
    logic [31:0] fa_x1_3, fa_x2_3, fa_y3, w_fy3, junk3;
    logic        fa_ovf3, busy3, frc3;
    logic [15:0] ovf_cnt3;
    assign {fa_ovf3, w_fy3} = fadd_ref(fa_x1_3, fa_x2_3);
    assign fa_y3 = frc3 ? junk3 : w_fy3;

    fadd_sched #(.NREQ(NREQ), .IDW(IDW), .LAT(3)) u_dut3 (
        .clk(clk), .rstn(rstn), .bus(bus3),
        .fa_x1(fa_x1_3), .fa_x2(fa_x2_3), .fa_y(fa_y3), .fa_ovf(fa_ovf3),
        .busy(busy3), .ovf_cnt(ovf_cnt3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_chk++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
        x1s[i] = a;
        x2s[i] = b;
        bus.req_x1[32*i +: 32] = a;
        bus.req_x2[32*i +: 32] = b;
        bus.req_valid[i]       = 1'b1;
    endtask

    function automatic int exp_grant();
        for (int k = 0; k < NREQ; k++) begin
            if (bus.req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // One arbitration round: grant, compute latency, optional back-pressure, completion
    task automatic txn(input int hold, input bit chk_gap);
        int              g;
        logic [32:0]     e;
        logic [NREQ-1:0] oh;
        bus.rsp_ready = (hold == 0);
        #1;
        g  = exp_grant();
        oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        chk("req_ready_idle", bus.req_ready, oh);
        chk("busy_idle", busy, 1'b0);
        if (g < 0) begin
            @(posedge clk); #1;
            return;
        end
        @(posedge clk);
        if (chk_gap && last_t >= 0) chk("issue_gap", $time - last_t, (LAT + 2) * 10);
        last_t = $time;
        #1;
        bus.req_valid[g] = 1'b0;
        e = fadd_ref(x1s[g], x2s[g]);
        chk("fa_x1", fa_x1, x1s[g]);
        chk("fa_x2", fa_x2, x2s[g]);
        for (int c = 0; c < LAT; c++) begin
            chk("rsp_valid_exec", bus.rsp_valid, 1'b0);
            chk("req_ready_exec", bus.req_ready, '0);
            @(posedge clk); #1;
        end
        if (e[32] && m_ovf < 16'hFFFF) m_ovf++;
        chk("rsp_valid", bus.rsp_valid, 1'b1);
        chk("rsp_id", bus.rsp_id, g);
        chk("rsp_y", bus.rsp_y, e[31:0]);
        chk("rsp_ovf", bus.rsp_ovf, e[32]);
        chk("ovf_cnt", ovf_cnt, m_ovf);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", bus.rsp_valid, 1'b1);
            chk("hold_y", bus.rsp_y, e[31:0]);
            chk("hold_id", bus.rsp_id, g);
            chk("hold_ready", bus.req_ready, '0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("done_valid", bus.rsp_valid, 1'b0);
        chk("done_busy", busy, 1'b0);
        m_ptr = (g + 1) % NREQ;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        logic [32:0] e;
        rstn = 1'b0;
        bus.req_valid = '0;  bus.req_x1 = '0;  bus.req_x2 = '0;  bus.rsp_ready = 1'b0;
        bus3.req_valid = '0; bus3.req_x1 = '0; bus3.req_x2 = '0; bus3.rsp_ready = 1'b0;
        frc3 = 1'b0; junk3 = '0;
        for (int i = 0; i < NREQ; i++) begin x1s[i] = '0; x2s[i] = '0; end
        bus.req_valid[0] = 1'b1;
        #23;
        chk("rst_ready", bus.req_ready, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_y", bus.rsp_y, 32'd0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_fa_x1", fa_x1, 32'd0);
        chk("rst_ovf_cnt", ovf_cnt, 16'd0);
        bus.req_valid = '0;
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed: 1.0 + 2.0, then max + max overflow on requester 2
        set_req(0, 32'h3F800000, 32'h40000000);
        txn(0, 1'b0);
        set_req(2, 32'h7F7FFFFF, 32'h7F7FFFFF);
        txn(0, 1'b0);
        set_req(3, 32'h3F800000, 32'h3F800000);
        txn(0, 1'b0);

        // All four held high: round-robin 0,1,2,3,0 at the minimum issue interval
        last_t = -1;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i]) set_req(i, 32'h3F800000 + (32'(i) == 0 ? 32'h0 :
                    (32'(i) == 1 ? 32'h00800000 : (32'(i) == 2 ? 32'h00C00000 : 32'h01000000))),
                    32'h3F800000);
            end
            txn(0, 1'b1);
        end
        bus.req_valid = '0;

        // Response back-pressure for 5 cycles
        set_req(1, 32'h40490FDB, 32'hC0000000);
        txn(5, 1'b0);

        // LAT=3 instance: adder output replaced during the first two EXEC cycles
        a = rnd_f(); b = rnd_f();
        e = fadd_ref(a, b);
        bus3.req_x1[63:32] = a; bus3.req_x2[63:32] = b;
        bus3.req_valid = 4'b0010; bus3.rsp_ready = 1'b1;
        frc3 = 1'b1; junk3 = $urandom;
        #1;
        chk("l3_ready", bus3.req_ready, 4'b0010);
        @(posedge clk); #1;
        bus3.req_valid = '0; junk3 = $urandom;
        chk("l3_exec1", bus3.rsp_valid, 1'b0);
        @(posedge clk); #1;
        junk3 = $urandom;
        chk("l3_exec2", bus3.rsp_valid, 1'b0);
        @(posedge clk); #1;
        frc3 = 1'b0;
        chk("l3_exec3", bus3.rsp_valid, 1'b0);
        chk("l3_fa_x1", fa_x1_3, a);
        @(posedge clk); #1;
        chk("l3_valid", bus3.rsp_valid, 1'b1);
        chk("l3_y", bus3.rsp_y, e[31:0]);
        chk("l3_id", bus3.rsp_id, 1);
        @(posedge clk); #1;
        chk("l3_done", busy3, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) set_req(i, rnd_f(), rnd_f());
            end
            txn($urandom_range(0, 3), 1'b0);
        end
        while (bus.req_valid != '0) txn(0, 1'b0);

        // Asynchronous reset in EXEC discards the op; requester 3 then wins first
        set_req(1, 32'h41200000, 32'h41A00000);
        #1;
        chk("r6_grant", bus.req_ready, 4'b0010);
        @(posedge clk); #1;
        bus.req_valid = '0;
        chk("r6_exec", busy, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk("r6_busy", busy, 1'b0);
        chk("r6_rsp_valid", bus.rsp_valid, 1'b0);
        chk("r6_fa_x1", fa_x1, 32'd0);
        chk("r6_ovf_cnt", ovf_cnt, 16'd0);
        @(posedge clk); #2;
        rstn = 1'b1;
        m_ptr = 0;
        m_ovf = 0;
        @(posedge clk); #1;
        chk("r6_idle", bus.rsp_valid, 1'b0);
        set_req(3, 32'h42280000, 32'h3F000000);
        txn(0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
